intr_ctrl: RTL and testbench
============================

# intr_ctrl

Parametrised, nesting-capable interrupt controller sitting beside the control unit and CP0 in the five-stage pipeline. It latches edge-triggered requests from `N_IRQ` sources and arbitrates them by fixed priority against the in-service set. It presents one request at a time to the pipeline, saves the interrupted PC on a per-level EPC stack, and unwinds one level per `eret`. It replaces the fixed three-source ints/irs encoding with registered state, true nesting and a computed vector.

## Interface
- `N_IRQ`, 3: number of interrupt sources; channel index = priority, with the highest index winning.
- `PC_W`, 32: PC / EPC / vector width.
- `VEC_BASE`, 32'h0000_1000: handler address of channel 0.
- `VEC_STRIDE`, 16: byte distance between consecutive channel vectors.
- `clk  in  1`: sole clock; all state updates on its rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `irq_in  in  N_IRQ`: raw request lines; a rising edge raises a request.
- `take  in  1`: pipeline commits the jump to `int_vec` this cycle. Meaningful only while `int_req`=1.
- `eret  in  1`: `eret` retires this cycle.
- `epc_in  in  PC_W`: PC to resume at, valid with `take`.
- `ie_w_en  in  1`, `ie_w_data  in  1`: mtc0 write of the global enable.
- `int_req  out  1`: an eligible interrupt is pending and `ie`=1.
- `int_id  out  ID_W`: ID_W = max(1, clog2(N_IRQ)); index of the winning channel.
- `int_vec  out  PC_W`: VEC_BASE + int_id*VEC_STRIDE.
- `epc_out  out  PC_W`: top of the EPC stack; 0 when empty.
- `ie  out  1`: global interrupt enable.
- `irs  out  N_IRQ`: in-service mask.
- `depth  out  clog2(N_IRQ+1)`: current nesting level.

## Operation
- Edge detect: `irq_q` is a registered copy of `irq_in`. On each edge, `pending[i]` is set if irq_in[i]=1 and irq_q[i]=0.
- Ceiling = highest set bit of `irs`, or -1 when `irs`=0. Eligible = pending bits strictly above the ceiling. `int_id` = highest eligible bit.
- `int_req` = ie AND (eligible≠0). All outputs are combinational from registers only; no input-to-output paths.
- Take (take=1 and int_req=1):
  - clears `pending[int_id]`.
  - sets `irs[int_id]`.
  - pushes `epc_in`.
  - sets `depth`+1.
  - sets `ie`=0.
- `take` while int_req=0 is ignored.
- Eret:
  - clears the highest `irs` bit.
  - pops the stack.
  - sets `depth`-1.
  - sets `ie`=1.
- Eret with depth=0: only `ie`=1 changes; no underflow.
- Depth never exceeds N_IRQ because each level is strictly higher priority. No overflow handling is required, but an assertion must check it.
- Simultaneous events:
  - take+eret in the same cycle: eret is processed and take is ignored. The pending bit stays set, so the request re-issues.
  - take + new edge on the same channel: pending ends set (the new edge re-latches).
  - ie_w_en together with take: take wins, ie=0.
  - ie_w_en together with eret: ie_w_data wins.
- Reset (asynchronous): pending, irq_q, irs, ie, depth, all stack entries, and hence every output are 0. int_vec = VEC_BASE. Reset asserted mid-handler discards all nesting state.

## Timing
- irq_in rising before edge E gives pending=1 and int_req=1 in the cycle after E: one cycle of latency.
- Take sampled at edge T: int_req re-evaluates from the cycle after T. It drops unless a higher-priority pending request exists, in which case it stays low only because ie=0.
- Eret at edge R: epc_out shows the next-lower level after R. A pending request above the new ceiling raises int_req after R (ie=1).
- A level-held irq_in produces exactly one request per rising edge.

## Structure
- Package `intr_pkg`:
  - `ID_W` and depth-width functions.
  - vector-computation function.
  - `intr_state_t` struct (pending, irs, ie, depth).
- Sub-module `epc_stack`: a parametrised LIFO with depth N_IRQ and width PC_W.
  - push and pop inputs; push and pop never both accepted.
  - top output; empty flag.
  - asynchronous clear on `rst`.
- Priority encoder and ceiling logic live inline.

## Test plan
- Basic: reset, ie_w 1, pulse irq_in[0], take with epc_in=0x40 → int_req is high one cycle after the edge, int_id=0, int_vec=0x1000; after take irs=001, epc_out=0x40, ie=0; eret → irs=0, depth=0, ie=1.
- Nesting: in handler 0 with ie re-enabled, pulse irq[2], take with epc 0x1008 → int_id=2, vec=0x1020, depth=2. Eret → epc_out=0x40, irs=001.
- Masking: in service of channel 2 with ie=1, pulse irq[1] → int_req stays 0. Eret → int_req=1, int_id=1 the next cycle.
- Conflicts:
  - take+eret in the same cycle → eret applied, request re-presented.
  - ie_w(0)+eret → ie=0.
  - eret at depth 0 → depth stays 0.
- Edge semantics: irq_in held high for 10 cycles → one take only. Drop and raise again → a second request.
- Reset mid-operation: assert rst at depth 2 → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared widths, vector arithmetic and the architectural state record
// of the nesting interrupt controller.
package intr_pkg;

    // Upper bound on sources; the state record is sized to this and
    // instances use the low N_IRQ bits.
    localparam int MAX_IRQ   = 16;
    localparam int MAX_DEP_W = 5;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int dep_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic logic [63:0] vec_addr(input logic [63:0] base,
                                             input logic [31:0] stride,
                                             input logic [31:0] id);
        return base + 64'(stride) * 64'(id);
    endfunction

    typedef struct packed {
        logic [MAX_IRQ-1:0]   pending;
        logic [MAX_IRQ-1:0]   irs;
        logic                 ie;
        logic [MAX_DEP_W-1:0] depth;
    } intr_state_t;

endpackage

// File: rtl/epc_stack.sv
// LIFO of saved return PCs, one entry per nesting level.
// Push and pop are never requested together by the controller.
module epc_stack #(
    parameter int DEPTH = 3,
    parameter int W     = 32,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (pop && cnt_q != '0) begin
            // Scrub the vacated slot so stale PCs never linger.
            mem_d[IDX_W'(cnt_q - CNT_W'(1))] = '0;
            cnt_d = cnt_q - CNT_W'(1);
        end else if (push && int'(cnt_q) < DEPTH) begin
            mem_d[IDX_W'(cnt_q)] = push_data;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

    assign empty = (cnt_q == '0);
    assign top   = empty ? '0 : mem_q[IDX_W'(cnt_q - CNT_W'(1))];

endmodule

// File: rtl/intr_ctrl.sv
// Fixed-priority nesting interrupt controller: edge-latched requests,
// in-service ceiling, computed vector and a per-level EPC stack.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int              N_IRQ      = 3,
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] VEC_BASE   = PC_W'(32'h0000_1000),
    parameter int unsigned     VEC_STRIDE = 16,
    localparam int ID_W  = id_w(N_IRQ),
    localparam int DEP_W = dep_w(N_IRQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IRQ-1:0]  irq_in,
    input  logic              take,
    input  logic              eret,
    input  logic [PC_W-1:0]   epc_in,
    input  logic              ie_w_en,
    input  logic              ie_w_data,
    output logic              int_req,
    output logic [ID_W-1:0]   int_id,
    output logic [PC_W-1:0]   int_vec,
    output logic [PC_W-1:0]   epc_out,
    output logic              ie,
    output logic [N_IRQ-1:0]  irs,
    output logic [DEP_W-1:0]  depth,
    output intr_state_t       dbg_state
);

    // Handshake: int_req/int_id/int_vec are registered-only outputs; the
    // pipeline acknowledges with take (ignored unless int_req=1), and eret
    // unwinds one level, taking precedence over a same-cycle take.

    intr_state_t      st_q, st_d;
    logic [N_IRQ-1:0] irq_q, irq_d;

    logic [N_IRQ-1:0] pending, irs_cur, above, eligible, rise;
    logic [N_IRQ-1:0] pend_n, irs_n;
    logic [DEP_W-1:0] depth_cur, depth_n;
    logic [ID_W-1:0]  win_id, top_irs;
    logic             req, take_ok, ie_n, seen;
    logic             stk_pop, stk_empty;
    logic [PC_W-1:0]  stk_top;

    assign pending   = st_q.pending[N_IRQ-1:0];
    assign irs_cur   = st_q.irs[N_IRQ-1:0];
    assign depth_cur = st_q.depth[DEP_W-1:0];

    // Ceiling: a channel is eligible only if nothing at or above it is in service.
    always_comb begin
        seen    = 1'b0;
        above   = '0;
        win_id  = '0;
        top_irs = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            seen     = seen | irs_cur[i];
            above[i] = ~seen;
        end
        for (int i = 0; i < N_IRQ; i++) begin
            if (pending[i] && above[i]) win_id = ID_W'(i);
            if (irs_cur[i]) top_irs = ID_W'(i);
        end
    end

    assign eligible = pending & above;
    assign req      = st_q.ie & (|eligible);
    assign take_ok  = take & req & ~eret;
    assign rise     = irq_in & ~irq_q;
    assign stk_pop  = eret & ~stk_empty;

    always_comb begin
        pend_n  = pending;
        irs_n   = irs_cur;
        depth_n = depth_cur;
        ie_n    = st_q.ie;
        irq_d   = irq_in;
        if (eret) begin
            if (|irs_cur) irs_n[top_irs] = 1'b0;
            if (depth_cur != '0) depth_n = depth_cur - DEP_W'(1);
            ie_n = 1'b1;
        end else if (take_ok) begin
            pend_n[win_id] = 1'b0;
            irs_n[win_id]  = 1'b1;
            depth_n        = depth_cur + DEP_W'(1);
        end
        if (ie_w_en) ie_n = ie_w_data;
        if (take_ok) ie_n = 1'b0;
        // A fresh edge re-latches even on the channel just taken.
        pend_n = pend_n | rise;

        st_d         = st_q;
        st_d.pending = MAX_IRQ'(pend_n);
        st_d.irs     = MAX_IRQ'(irs_n);
        st_d.ie      = ie_n;
        st_d.depth   = MAX_DEP_W'(depth_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= '0;
            irq_q <= '0;
        end else begin
            st_q  <= st_d;
            irq_q <= irq_d;
        end
    end

    epc_stack #(
        .DEPTH (N_IRQ),
        .W     (PC_W)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (take_ok),
        .pop       (stk_pop),
        .push_data (epc_in),
        .top       (stk_top),
        .empty     (stk_empty)
    );

    assign int_req   = req;
    assign int_id    = win_id;
    assign int_vec   = PC_W'(vec_addr(64'(VEC_BASE), VEC_STRIDE, 32'(win_id)));
    assign epc_out   = stk_top;
    assign ie        = st_q.ie;
    assign irs       = irs_cur;
    assign depth     = depth_cur;
    assign dbg_state = st_q;

    // Each level is strictly higher priority, so nesting is bounded by N_IRQ.
    a_depth_bound: assert property (@(posedge clk) disable iff (rst)
        int'(depth_cur) <= N_IRQ);

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: basic take/eret, nesting, masking,
// conflict cases, edge semantics and asynchronous reset mid-handler.
module tb_intr_ctrl;
    import intr_pkg::*;

    localparam int N_IRQ = 3;
    localparam int PC_W  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N_IRQ-1:0]  irq_in = '0;
    logic              take = 1'b0;
    logic              eret = 1'b0;
    logic [PC_W-1:0]   epc_in = '0;
    logic              ie_w_en = 1'b0;
    logic              ie_w_data = 1'b0;
    logic              int_req;
    logic [1:0]        int_id;
    logic [PC_W-1:0]   int_vec;
    logic [PC_W-1:0]   epc_out;
    logic              ie;
    logic [N_IRQ-1:0]  irs;
    logic [1:0]        depth;
    intr_state_t       dbg_state;

    int n_assert = 0;
    int n_fail   = 0;

    intr_ctrl #(
        .N_IRQ      (N_IRQ),
        .PC_W       (PC_W),
        .VEC_BASE   (32'h0000_1000),
        .VEC_STRIDE (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .take      (take),
        .eret      (eret),
        .epc_in    (epc_in),
        .ie_w_en   (ie_w_en),
        .ie_w_data (ie_w_data),
        .int_req   (int_req),
        .int_id    (int_id),
        .int_vec   (int_vec),
        .epc_out   (epc_out),
        .ie        (ie),
        .irs       (irs),
        .depth     (depth),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [1:0] id,
                           input logic [31:0] vec);
        chk({tag, "_req"}, 64'(int_req), 64'(r));
        if (r) begin
            chk({tag, "_id"}, 64'(int_id), 64'(id));
            chk({tag, "_vec"}, 64'(int_vec), 64'(vec));
        end
    endtask

    task automatic chk_lvl(input string tag, input logic [2:0] e_irs, input logic [1:0] e_depth,
                           input logic e_ie, input logic [31:0] e_epc);
        chk({tag, "_irs"}, 64'(irs), 64'(e_irs));
        chk({tag, "_depth"}, 64'(depth), 64'(e_depth));
        chk({tag, "_ie"}, 64'(ie), 64'(e_ie));
        chk({tag, "_epc"}, 64'(epc_out), 64'(e_epc));
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk_lvl("reset", 3'b000, 2'd0, 1'b0, 32'h0);
        chk("reset_req", 64'(int_req), 64'(0));
        chk("reset_vec", 64'(int_vec), 64'(32'h1000));
        rst = 1'b0;
        step();

        // Basic: enable, pulse irq0, take, eret
        ie_w_en = 1'b1; ie_w_data = 1'b1;
        step();
        ie_w_en = 1'b0;
        chk("ie_write", 64'(ie), 64'(1));
        irq_in = 3'b001;
        step();
        irq_in = 3'b000;
        chk_req("basic", 1'b1, 2'd0, 32'h1000);
        take = 1'b1; epc_in = 32'h40;
        step();
        take = 1'b0;
        chk_lvl("basic_take", 3'b001, 2'd1, 1'b0, 32'h40);
        chk("basic_take_req", 64'(int_req), 64'(0));
        eret = 1'b1;
        step();
        eret = 1'b0;
        chk_lvl("basic_eret", 3'b000, 2'd0, 1'b1, 32'h0);

        // Nesting: re-enter handler 0, re-enable, take channel 2 on top
        irq_in = 3'b001;
        step();
        irq_in = 3'b000;
        take = 1'b1; epc_in = 32'h40;
        step();
        take = 1'b0;
        ie_w_en = 1'b1; ie_w_data = 1'b1;
        step();
        ie_w_en = 1'b0;
        irq_in = 3'b100;
        step();
        irq_in = 3'b000;
        chk_req("nest", 1'b1, 2'd2, 32'h1020);
        take = 1'b1; epc_in = 32'h1008;
        step();
        take = 1'b0;
        chk_lvl("nest_take", 3'b101, 2'd2, 1'b0, 32'h1008);

        // Masking: channel 1 below ceiling 2 must wait
        ie_w_en = 1'b1; ie_w_data = 1'b1;
        step();
        ie_w_en = 1'b0;
        irq_in = 3'b010;
        step();
        irq_in = 3'b000;
        chk("mask_req", 64'(int_req), 64'(0));
        step();
        chk("mask_req_hold", 64'(int_req), 64'(0));
        eret = 1'b1;
        step();
        eret = 1'b0;
        chk_lvl("nest_eret", 3'b001, 2'd1, 1'b1, 32'h40);
        chk_req("unmask", 1'b1, 2'd1, 32'h1010);

        // take+eret together: eret wins, request re-presented
        take = 1'b1; eret = 1'b1; epc_in = 32'h77;
        step();
        take = 1'b0; eret = 1'b0;
        chk_lvl("take_eret", 3'b000, 2'd0, 1'b1, 32'h0);
        chk_req("take_eret", 1'b1, 2'd1, 32'h1010);
        take = 1'b1; epc_in = 32'h88;
        step();
        take = 1'b0;
        chk_lvl("retake", 3'b010, 2'd1, 1'b0, 32'h88);

        // ie write of 0 together with eret: write data wins
        ie_w_en = 1'b1; ie_w_data = 1'b0; eret = 1'b1;
        step();
        ie_w_en = 1'b0; eret = 1'b0;
        chk_lvl("iew_eret", 3'b000, 2'd0, 1'b0, 32'h0);

        // eret at depth 0 only sets ie
        eret = 1'b1;
        step();
        eret = 1'b0;
        chk_lvl("eret_empty", 3'b000, 2'd0, 1'b1, 32'h0);

        // take without a request is ignored
        take = 1'b1; epc_in = 32'h123;
        step();
        take = 1'b0;
        chk_lvl("take_idle", 3'b000, 2'd0, 1'b1, 32'h0);

        // Level-held request yields one take only
        irq_in = 3'b001;
        step();
        chk_req("held", 1'b1, 2'd0, 32'h1000);
        take = 1'b1; epc_in = 32'h50;
        step();
        take = 1'b0;
        ie_w_en = 1'b1; ie_w_data = 1'b1;
        step();
        ie_w_en = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("held_req", 64'(int_req), 64'(0));
        eret = 1'b1;
        step();
        eret = 1'b0;
        chk("held_after_eret_req", 64'(int_req), 64'(0));
        chk("held_pend0", 64'(dbg_state.pending[0]), 64'(0));
        irq_in = 3'b000;
        step();
        irq_in = 3'b001;
        step();
        chk_req("reraise", 1'b1, 2'd0, 32'h1000);

        // take coinciding with a new edge on the same channel
        irq_in = 3'b000;
        step();
        chk("pre_relatch_req", 64'(int_req), 64'(1));
        take = 1'b1; epc_in = 32'h99; irq_in = 3'b001;
        step();
        take = 1'b0;
        chk("relatch_pend0", 64'(dbg_state.pending[0]), 64'(1));
        chk_lvl("relatch", 3'b001, 2'd1, 1'b0, 32'h99);
        eret = 1'b1;
        step();
        eret = 1'b0;
        chk_req("relatch_eret", 1'b1, 2'd0, 32'h1000);

        // Asynchronous reset at depth 2
        take = 1'b1; epc_in = 32'h10;
        step();
        take = 1'b0;
        ie_w_en = 1'b1; ie_w_data = 1'b1;
        step();
        ie_w_en = 1'b0;
        irq_in = 3'b101;
        step();
        chk_req("pre_rst", 1'b1, 2'd2, 32'h1020);
        take = 1'b1; epc_in = 32'h20;
        step();
        take = 1'b0;
        chk_lvl("pre_rst_lvl", 3'b101, 2'd2, 1'b0, 32'h20);
        rst = 1'b1;
        #1;
        chk_lvl("async_rst", 3'b000, 2'd0, 1'b0, 32'h0);
        chk("async_rst_req", 64'(int_req), 64'(0));
        chk("async_rst_id", 64'(int_id), 64'(0));
        chk("async_rst_vec", 64'(int_vec), 64'(32'h1000));
        irq_in = 3'b000;
        step();
        step();
        rst = 1'b0;
        step();
        chk("post_rst_req", 64'(int_req), 64'(0));
        chk("post_rst_depth", 64'(depth), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
